// File: rtl/noc_pkg.sv
// Shared NoC types: flit width, flit type, stats counter width and
// a saturating increment helper for the stats counter.
package noc_pkg;

  localparam int FLIT_WIDTH  = 32;
  localparam int STATS_CNT_W = 32;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [STATS_CNT_W-1:0] sat_inc(
    input logic [STATS_CNT_W-1:0] v
  );
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_drain_skid_buf2.sv
// skid_buf2: 2-entry in-order buffer with wrapping head/tail pointers.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_wr         write i_wdata at tail this cycle
//   i_wdata      write data
//   i_deq        release the head entry this cycle
//   o_count      occupied entries, 0..2
//   o_head_data  head entry, straight from the storage flops
module skid_buf2
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_deq,
  output logic [1:0]       o_count,
  output logic [WIDTH-1:0] o_head_data
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             head_q;
  logic             head_d;
  logic             tail_q;
  logic             tail_d;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_wr) begin
      mem_d[tail_q] = i_wdata;
      tail_d        = ~tail_q;
    end
    if (i_deq) begin
      head_d = ~head_q;
    end
    // Simultaneous write and dequeue leave the occupancy unchanged.
    unique case ({i_wr, i_deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately not reset; only the control state is.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_count     = count_q;
  assign o_head_data = mem_q[head_q];

  a_count_range: assert property (
    @(posedge clk) count_q <= 2'd2
  );

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(i_wr && !i_deq && (count_q == 2'd2))
  );

  a_no_underflow: assert property (
    @(posedge clk) disable iff (rst)
    !(i_deq && (count_q == 2'd0))
  );

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pops a FIFO and streams flits on valid/ready at 1/cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   o_pop         pop request to the FIFO (comb from i_ready/i_empty)
//   i_empty       FIFO empty flag (registered in the FIFO)
//   i_rdata       FIFO read data, valid RLATENCY cycles after pop
//   o_valid       output flit valid (from flops)
//   i_ready       downstream accepts the flit
//   o_data        output flit (from flops)
//   o_flit_count  delivered flits, saturating; only with
//                 FIFO_DRAIN_STATS_EN defined
module fifo_drain
  import noc_pkg::*;
#(
  parameter int WIDTH    = FLIT_WIDTH,
  parameter int RLATENCY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   o_pop,
  input  logic                   i_empty,
  input  logic [WIDTH-1:0]       i_rdata,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       o_data
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0] o_flit_count
`endif
);

  if ((RLATENCY != 0) && (RLATENCY != 1)) begin : g_bad_lat
    $error("fifo_drain: RLATENCY must be 0 or 1");
  end

  logic [1:0] count;
  logic       inflight;
  logic       wr;
  logic       deq;
  logic [2:0] occ;

  assign o_valid = (count != 2'd0);
  assign deq     = o_valid && i_ready;

  // Occupancy the buffer will have after this cycle's dequeue,
  // counting data already requested from the FIFO. deq implies
  // count >= 1, so this never underflows.
  always_comb begin
    occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
    o_pop = !rst && !i_empty && (occ < 3'd2);
  end

  if (RLATENCY == 1) begin : g_lat1
    logic inflight_q;
    logic inflight_d;

    always_comb begin
      inflight_d = o_pop;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= inflight_d;
      end
    end

    // Data for last cycle's pop is on i_rdata now.
    assign inflight = inflight_q;
    assign wr       = inflight_q;
  end else begin : g_lat0
    // First-word fall-through: data is valid in the pop cycle.
    assign inflight = 1'b0;
    assign wr       = o_pop;
  end

  skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_wr       (wr),
    .i_wdata    (i_rdata),
    .i_deq      (deq),
    .o_count    (count),
    .o_head_data(o_data)
  );

`ifdef FIFO_DRAIN_STATS_EN
  logic [STATS_CNT_W-1:0] flit_count_q;
  logic [STATS_CNT_W-1:0] flit_count_d;

  always_comb begin
    flit_count_d = flit_count_q;
    if (deq) begin
      flit_count_d = sat_inc(flit_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_count_q <= '0;
    end else begin
      flit_count_q <= flit_count_d;
    end
  end

  assign o_flit_count = flit_count_q;
`endif

  a_no_pop_empty: assert property (
    @(posedge clk) !(o_pop && i_empty)
  );

  a_stall_stable: assert property (
    @(posedge clk) disable iff (rst)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_data))
  );

  a_known: assert property (
    @(posedge clk) disable iff (rst)
    !$isunknown({o_valid, o_pop})
  );

endmodule
